// File: rtl/ps2_device.sv
// ps2_device: device side of a PS/2 link (mouse/keyboard emulation).
// Generates the PS/2 clock, sends frames, and receives host RTS frames with ack.
module ps2_device #(
  parameter int CLK_HALF = 2000,
  parameter int IDLE_MIN = 2500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Write,
  input  logic [7:0] TxData,
  output logic       TxReady,
  output logic       TxDone,
  output logic       TxAbort,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       RxError,
  inout  wire        PS2Clk,
  inout  wire        PS2Data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TX_HI  = 3'd1;
  localparam logic [2:0] TX_LO  = 3'd2;
  localparam logic [2:0] RX_HI  = 3'd3;
  localparam logic [2:0] RX_LO  = 3'd4;
  localparam logic [2:0] ACK_HI = 3'd5;
  localparam logic [2:0] ACK_LO = 3'd6;

  localparam int HW = $clog2(CLK_HALF);
  localparam int IW = $clog2(IDLE_MIN + 1);
  localparam logic [HW-1:0] H_LAST = HW'(CLK_HALF - 1);
  localparam logic [HW-1:0] H_MARG = HW'(3);
  localparam logic [IW-1:0] I_MAX  = IW'(IDLE_MIN);
  localparam logic [3:0]    B_LAST = 4'd10;

  logic          clk_s1;
  logic          clk_s2;
  logic          dat_s1;
  logic          dat_s2;
  logic          clk_oe;
  logic          dat_oe;
  logic [2:0]    state;
  logic [HW-1:0] hcnt;
  logic [3:0]    bidx;
  logic [10:0]   shreg;
  logic [IW-1:0] idle_cnt;
  logic          rts_hit;

  logic h_end;
  logic in_win;
  logic rts_cond;
  logic tx_go;

  assign PS2Clk  = clk_oe ? 1'b0 : 1'bz;
  assign PS2Data = dat_oe ? 1'b0 : 1'bz;

  assign h_end    = (hcnt == H_LAST);
  assign in_win   = (hcnt >= H_MARG);
  assign rts_cond = clk_s2 && !dat_s2;
  assign TxReady  = (state == IDLE) && (idle_cnt == I_MAX) && dat_s2;
  assign tx_go    = Write && TxReady;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      dat_s1 <= 1'b0;
      dat_s2 <= 1'b0;
    end else begin
      clk_s1 <= PS2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2Data;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      bidx     <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
      rts_hit  <= 1'b0;
      clk_oe   <= 1'b0;
      dat_oe   <= 1'b0;
      TxDone   <= 1'b0;
      TxAbort  <= 1'b0;
      RxDone   <= 1'b0;
      RxError  <= 1'b0;
      RxData   <= '0;
    end else begin
      TxDone  <= 1'b0;
      TxAbort <= 1'b0;
      RxDone  <= 1'b0;
      RxError <= 1'b0;
      rts_hit <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          hcnt   <= '0;
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          rts_hit <= rts_cond;
          if (clk_s2 && dat_s2)
            idle_cnt <= (idle_cnt == I_MAX) ? I_MAX : idle_cnt + 1'b1;
          else
            idle_cnt <= '0;
          // RTS wins over Write; TxReady is already low while data is low
          if (rts_hit && rts_cond) begin
            state    <= RX_HI;
            bidx     <= 4'd1;
            shreg    <= '0;
            idle_cnt <= '0;
            rts_hit  <= 1'b0;
          end else if (tx_go) begin
            state    <= TX_HI;
            bidx     <= '0;
            shreg    <= {1'b1, ~^TxData, TxData, 1'b0};
            dat_oe   <= 1'b1;
            idle_cnt <= '0;
          end
        end
        (state == TX_HI): begin
          if (bidx != B_LAST && in_win && !clk_s2) begin
            state   <= IDLE;
            hcnt    <= '0;
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b0;
            TxAbort <= 1'b1;
          end else if (h_end) begin
            state  <= TX_LO;
            hcnt   <= '0;
            clk_oe <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        (state == TX_LO): begin
          if (h_end) begin
            hcnt   <= '0;
            clk_oe <= 1'b0;
            if (bidx == B_LAST) begin
              state  <= IDLE;
              dat_oe <= 1'b0;
              TxDone <= 1'b1;
            end else begin
              state  <= TX_HI;
              bidx   <= bidx + 4'd1;
              shreg  <= {1'b1, shreg[10:1]};
              dat_oe <= ~shreg[1];
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        (state == RX_HI): begin
          if (in_win && !clk_s2) begin
            state   <= IDLE;
            hcnt    <= '0;
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b0;
            RxDone  <= 1'b1;
            RxError <= 1'b1;
          end else if (h_end) begin
            state  <= RX_LO;
            hcnt   <= '0;
            clk_oe <= 1'b1;
            shreg  <= {dat_s2, shreg[10:1]};
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        (state == RX_LO): begin
          if (h_end) begin
            hcnt   <= '0;
            clk_oe <= 1'b0;
            if (bidx != B_LAST) begin
              state <= RX_HI;
              bidx  <= bidx + 4'd1;
            end else if (shreg[10]) begin
              state  <= ACK_HI;
              dat_oe <= 1'b1;
            end else begin
              state   <= IDLE;
              RxDone  <= 1'b1;
              RxError <= 1'b1;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        (state == ACK_HI): begin
          if (h_end) begin
            state  <= ACK_LO;
            hcnt   <= '0;
            clk_oe <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        (state == ACK_LO): begin
          if (h_end) begin
            state   <= IDLE;
            hcnt    <= '0;
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b0;
            RxData  <= shreg[8:1];
            RxDone  <= 1'b1;
            RxError <= ~(^shreg[9:1]);
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          hcnt   <= '0;
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
// tb_ps2_device: directed bench for ps2_device with a simple PS/2 host model.
// Device transmit, host RTS receive, abort, reset and write-blocking cases.
module tb_ps2_device;

  localparam int CH = 4;
  localparam int IM = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_abort;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  wire        ps2_clk;
  wire        ps2_data;
  logic       h_clk_lo = 1'b0;
  logic       h_dat_lo = 1'b0;

  int total = 0;
  int bad = 0;

  logic [10:0] txb;
  int nfall;
  int nrise;
  int done_at;
  int abort_at;
  int pull_at;

  logic       got;
  logic [7:0] rdata;
  logic       rerr;
  logic       ack_hi;
  logic       ack_lo;
  logic       rdy_mid;
  logic       rdy_rts;
  int         rfalls;
  int         txd;
  int         extra;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = h_clk_lo ? 1'b0 : 1'bz;
  assign ps2_data = h_dat_lo ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_device #(.CLK_HALF(CH), .IDLE_MIN(IM)) dut (
    .Clk     (clk),
    .Reset   (rst_n),
    .Write   (wr),
    .TxData  (tx_data),
    .TxReady (tx_ready),
    .TxDone  (tx_done),
    .TxAbort (tx_abort),
    .RxData  (rx_data),
    .RxDone  (rx_done),
    .RxError (rx_error),
    .PS2Clk  (ps2_clk),
    .PS2Data (ps2_data)
  );

  task automatic chk(input string tag, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int abort_rise,
                      input int rst_at);
    logic pc;
    logic cur;
    int w;
    txb = '0;
    nfall = 0;
    nrise = 0;
    done_at = -1;
    abort_at = -1;
    pull_at = -1;
    w = 0;
    while (!tx_ready && w < 400) begin
      tick();
      w++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data = d;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    chk("tx_first_drive", 32'(ps2_data), 32'd0);
    pc = ps2_clk;
    for (int n = 1; n <= 120; n++) begin
      tick();
      if (n == rst_at) begin
        chk("pre_rst_lines", 32'({ps2_clk, ps2_data}), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_lines", 32'({ps2_clk, ps2_data}), 32'd3);
        chk("rst_outs", 32'({tx_ready, tx_done, tx_abort, rx_done,
                             rx_error, rx_data}), 32'd0);
        break;
      end
      cur = ps2_clk;
      if (pc && !cur) begin
        if (nfall < 11) txb[nfall] = ps2_data;
        nfall++;
      end
      if (!pc && cur) begin
        nrise++;
        if (nrise == abort_rise) begin
          h_clk_lo = 1'b1;
          pull_at = n;
          cur = 1'b0;
        end
      end
      pc = cur;
      if (pull_at > 0 && n == pull_at + 8) begin
        h_clk_lo = 1'b0;
        pc = 1'b1;
      end
      if (pull_at > 0 && n == pull_at + 10)
        chk("abort_release", 32'({ps2_clk, ps2_data}), 32'd3);
      if (tx_done && done_at < 0) done_at = n;
      if (tx_abort && abort_at < 0) abort_at = n;
      if (done_at > 0 && n == done_at + IM - 1)
        chk("ready_early", 32'(tx_ready), 32'd0);
      if (done_at > 0 && n == done_at + IM + 4)
        chk("ready_back", 32'(tx_ready), 32'd1);
    end
  endtask

  task automatic host_send(input logic [7:0] d, input logic par,
                           input logic wr_rts, input logic wr_mid);
    logic [10:0] f;
    logic pc;
    logic cur;
    logic mid;
    f = {1'b1, par, d, 1'b0};
    got = 1'b0;
    rdata = 8'h00;
    rerr = 1'b0;
    ack_hi = 1'b1;
    ack_lo = 1'b1;
    rdy_mid = 1'b1;
    rdy_rts = 1'b1;
    rfalls = 0;
    txd = 0;
    extra = 0;
    mid = 1'b0;
    h_clk_lo = 1'b1;
    repeat (6) tick();
    h_dat_lo = 1'b1;
    repeat (2) tick();
    h_clk_lo = 1'b0;
    pc = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      wr = (wr_rts && n <= 6) || mid;
      mid = 1'b0;
      tick();
      if (n == 3) h_dat_lo = ~f[1];
      if (n == 4) rdy_rts = tx_ready;
      cur = ps2_clk;
      if (pc && !cur) begin
        rfalls++;
        if (rfalls <= 9) h_dat_lo = ~f[rfalls+1];
        if (rfalls == 11) ack_lo = ps2_data;
        if (wr_mid && rfalls == 5) begin
          rdy_mid = tx_ready;
          mid = 1'b1;
        end
      end
      if (!pc && cur && rfalls == 10) ack_hi = ps2_data;
      pc = cur;
      if (tx_done) txd++;
      if (rx_done) begin
        got = 1'b1;
        rdata = rx_data;
        rerr = rx_error;
        break;
      end
    end
    wr = 1'b0;
    h_dat_lo = 1'b0;
    repeat (30) begin
      tick();
      if (!ps2_clk) extra++;
      if (tx_done) txd++;
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_lines", 32'({ps2_clk, ps2_data}), 32'd3);
    chk("reset_outs", 32'({tx_ready, tx_done, tx_abort, rx_done,
                           rx_error, rx_data}), 32'd0);
    rst_n = 1'b1;

    send(8'hA5, 0, 0);
    chk("a5_bits", 32'(txb), 32'h74A);
    chk("a5_falls", 32'(nfall), 32'd11);
    chk("a5_done_at", 32'(done_at), 32'd88);
    chk("a5_no_abort", 32'(abort_at), 32'hFFFF_FFFF);

    repeat (20) tick();
    host_send(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("rx3c_done", 32'(got), 32'd1);
    chk("rx3c_data", 32'(rdata), 32'h3C);
    chk("rx3c_err", 32'(rerr), 32'd0);
    chk("rx3c_ack_hi", 32'(ack_hi), 32'd0);
    chk("rx3c_ack_lo", 32'(ack_lo), 32'd0);
    chk("rx3c_pulses", 32'(rfalls), 32'd11);

    repeat (20) tick();
    host_send(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("rxpe_done", 32'(got), 32'd1);
    chk("rxpe_data", 32'(rdata), 32'h3C);
    chk("rxpe_err", 32'(rerr), 32'd1);
    chk("rxpe_ack_lo", 32'(ack_lo), 32'd0);
    chk("rxpe_pulses", 32'(rfalls), 32'd11);

    send(8'hFF, 4, 0);
    chk("ab_pull_at", 32'(pull_at), 32'd32);
    chk("ab_latency", 32'(abort_at >= 0 && abort_at - pull_at <= 4), 32'd1);
    chk("ab_no_done", 32'(done_at), 32'hFFFF_FFFF);
    repeat (10) tick();
    host_send(8'hF4, 1'b0, 1'b0, 1'b0);
    chk("rxf4_done", 32'(got), 32'd1);
    chk("rxf4_data", 32'(rdata), 32'hF4);
    chk("rxf4_err", 32'(rerr), 32'd0);

    send(8'h00, 0, 53);
    begin
      logic ok;
      int since;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_ready", 32'(tx_ready), 32'd0);
      wr = 1'b1;
      tx_data = 8'h00;
      tick();
      wr = 1'b0;
      ok = 1'b1;
      repeat (6) begin
        if (ps2_data !== 1'b1 || ps2_clk !== 1'b1) ok = 1'b0;
        tick();
      end
      chk("post_rst_wr_ignored", 32'(ok), 32'd1);
      since = 10;
      while (!tx_ready && since < 200) begin
        tick();
        since++;
      end
      chk("post_rst_idle_min", 32'(since >= IM && tx_ready), 32'd1);
    end

    repeat (5) tick();
    host_send(8'h5A, 1'b1, 1'b1, 1'b1);
    chk("rxwr_done", 32'(got), 32'd1);
    chk("rxwr_data", 32'(rdata), 32'h5A);
    chk("rxwr_err", 32'(rerr), 32'd0);
    chk("rxwr_pulses", 32'(rfalls), 32'd11);
    chk("rxwr_rts_ready", 32'(rdy_rts), 32'd0);
    chk("rxwr_mid_ready", 32'(rdy_mid), 32'd0);
    chk("rxwr_no_txdone", 32'(txd), 32'd0);
    chk("rxwr_no_frame", 32'(extra), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
